// File: rtl/inst_encoder.sv
// inst_encoder -- packs decoded instruction fields back into a 32-bit RV32IM word.
//
// Inverse of the core instruction decoder. Used by self-check/trace replay and by the
// boot-sequence generator. Each accepted field bundle is encoded combinationally and
// pushed into a small output FIFO. Bundles that do not map to a legal encoding produce
// a NOP (32'h0000_0013) tagged with out_err.
//
// Parameters:
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
//   CNT_W       width of enc_cnt / err_cnt (both wrap)
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   field bundle handshake; in_ready = FIFO not full
//   in_code               {b11, b10, funct3[2:0], opcode[6:0]}; 12'hFFF = illegal marker
//   in_rd, in_rs1, in_rs2 register fields
//   in_imm                immediate in decoder (sign-extended) layout
//   out_valid / out_ready encoded word handshake; out_valid = FIFO not empty
//   out_inst, out_err     FIFO head word and its unencodable flag (0 when empty)
//   enc_cnt, err_cnt      running counts of legal / illegal accepted bundles
//
// Optional build macro:
//   ENC_IRQ_EN  makes opcode 7'b0011000 with funct3 != 0 legal (I-style layout).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge; the FIFO
// keeps out_inst/out_err stable while out_valid && !out_ready. Push and pop may
// happen in the same cycle, leaving occupancy unchanged.

module inst_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_code,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
`ifdef ENC_IRQ_EN
  localparam logic [6:0] OP_IRQ    = 7'b0011000;
`endif

  // ---------------------------------------------------------------------------
  // Field extraction and combinational encode
  // ---------------------------------------------------------------------------
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        b10;
  logic        b11;
  logic [31:0] i_word;
  logic [31:0] enc_inst;
  logic        enc_err;

  assign op  = in_code[6:0];
  assign f3  = in_code[9:7];
  assign b10 = in_code[10];
  assign b11 = in_code[11];

  // Shared I-type layout (JALR, loads, SYSTEM, OP-IMM non-shift, IRQ)
  assign i_word = {in_imm[11:0], in_rs1, f3, in_rd, op};

  always_comb begin
    enc_inst = NOP;
    enc_err  = 1'b1;
    case (op)
      OP_LUI, OP_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, op};
        enc_err  = 1'b0;
      end
      OP_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
        enc_err  = 1'b0;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          enc_inst = i_word;
          enc_err  = 1'b0;
        end
      end
      OP_LOAD: begin
        // LB, LH, LW, LBU, LHU only
        if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          enc_inst = i_word;
          enc_err  = 1'b0;
        end
      end
      OP_SYSTEM: begin
        if (f3 != 3'b100) begin
          enc_inst = i_word;
          enc_err  = 1'b0;
        end
      end
      OP_IMM: begin
        // funct3 001/101 are the shifts: 5-bit shamt, b10 selects arithmetic
        if (f3[1:0] == 2'b01) begin
          enc_inst = {1'b0, b10, 5'b0, in_imm[4:0], in_rs1, f3, in_rd, op};
        end else begin
          enc_inst = i_word;
        end
        enc_err = 1'b0;
      end
      OP_STORE: begin
        if (f3 inside {3'b000, 3'b001, 3'b010}) begin
          enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], op};
          enc_err  = 1'b0;
        end
      end
      OP_BRANCH: begin
        // funct3 010/011 are unassigned branch codes
        if (f3[2:1] != 2'b01) begin
          enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                      in_imm[4:1], in_imm[11], op};
          enc_err  = 1'b0;
        end
      end
      OP_REG: begin
        // b10 marks the M extension; divide/remainder (f3[2]) is not supported
        if (!(b10 && f3[2])) begin
          enc_inst = {1'b0, b11, 4'b0, b10, in_rs2, in_rs1, f3, in_rd, op};
          enc_err  = 1'b0;
        end
      end
`ifdef ENC_IRQ_EN
      OP_IRQ: begin
        if (f3 != 3'b000) begin
          enc_inst = i_word;
          enc_err  = 1'b0;
        end
      end
`endif
      default: begin
        enc_inst = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic          mem_err  [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign in_ready  = (count != DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is forced to zero when empty so the outputs read 0 after reset and drain.
  assign out_inst = out_valid ? mem_inst[rd_ptr] : 32'h0;
  assign out_err  = out_valid ? mem_err[rd_ptr]  : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      enc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (enc_err) err_cnt <= err_cnt + CNT_W'(1);
        else         enc_cnt <= enc_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= enc_inst;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder -- self-checking bench for inst_encoder.
// Directed literal cases, backpressure and mid-operation reset, then randomized
// traffic compared every cycle against a queue-based reference model.

module tb_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CW    = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   in_code = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_err;
  logic [CW-1:0] enc_cnt;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  inst_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: legality table per opcode (bit f3 set = legal), then the
  // word is assembled by shifting immediate slices into place.
  // Returns {err, inst}.
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] model_enc(input logic [11:0] code, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] opv, f3v, b10v, b11v, rdv, rs1v, rs2v, w;
    logic [7:0]  legal_f3;
    int          fmt; // 0 none, 1 U, 2 J, 3 I, 4 shift, 5 S, 6 B, 7 R
    opv  = 32'(code) & 32'h7F;
    f3v  = (32'(code) >> 7) & 32'h7;
    b10v = (32'(code) >> 10) & 32'h1;
    b11v = (32'(code) >> 11) & 32'h1;
    rdv  = 32'(rd);
    rs1v = 32'(rs1);
    rs2v = 32'(rs2);
    legal_f3 = 8'h00;
    fmt = 0;
    case (opv)
      32'h37, 32'h17: begin legal_f3 = 8'hFF; fmt = 1; end
      32'h6F:         begin legal_f3 = 8'hFF; fmt = 2; end
      32'h67:         begin legal_f3 = 8'b0000_0001; fmt = 3; end
      32'h03:         begin legal_f3 = 8'b0011_0111; fmt = 3; end
      32'h73:         begin legal_f3 = 8'b1110_1111; fmt = 3; end
      32'h13:         begin legal_f3 = 8'hFF; fmt = ((f3v == 1) || (f3v == 5)) ? 4 : 3; end
      32'h23:         begin legal_f3 = 8'b0000_0111; fmt = 5; end
      32'h63:         begin legal_f3 = 8'b1111_0011; fmt = 6; end
      32'h33:         begin legal_f3 = (b10v != 0) ? 8'b0000_1111 : 8'hFF; fmt = 7; end
`ifdef ENC_IRQ_EN
      32'h18:         begin legal_f3 = 8'b1111_1110; fmt = 3; end
`endif
      default:        begin legal_f3 = 8'h00; fmt = 0; end
    endcase
    if (legal_f3[f3v[2:0]] == 1'b0) fmt = 0;
    case (fmt)
      1: w = (imm & 32'hFFFF_F000) | (rdv << 7) | opv;
      2: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
             (rdv << 7) | opv;
      3: w = ((imm & 32'hFFF) << 20) | (rs1v << 15) | (f3v << 12) | (rdv << 7) | opv;
      4: w = (b10v << 30) | ((imm & 32'h1F) << 20) | (rs1v << 15) | (f3v << 12) |
             (rdv << 7) | opv;
      5: w = (((imm >> 5) & 32'h7F) << 25) | (rs2v << 20) | (rs1v << 15) | (f3v << 12) |
             ((imm & 32'h1F) << 7) | opv;
      6: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
             (rs2v << 20) | (rs1v << 15) | (f3v << 12) |
             (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | opv;
      7: w = (b11v << 30) | (b10v << 25) | (rs2v << 20) | (rs1v << 15) | (f3v << 12) |
             (rdv << 7) | opv;
      default: w = 32'h0000_0013;
    endcase
    return {(fmt == 0), w};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard: expected FIFO contents and counters
  // ---------------------------------------------------------------------------
  logic [32:0]   exp_q[$];
  logic [CW-1:0] m_enc;
  logic [CW-1:0] m_err;
  logic [32:0]   m_word;
  bit            m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_enc = '0;
      m_err = '0;
    end else begin
      m_push = in_valid && (exp_q.size() < DEPTH);
      if (out_ready && (exp_q.size() != 0)) void'(exp_q.pop_front());
      if (m_push) begin
        m_word = model_enc(in_code, in_rd, in_rs1, in_rs2, in_imm);
        exp_q.push_back(m_word);
        if (m_word[32]) m_err = m_err + 1'b1;
        else            m_enc = m_enc + 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("cyc out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("cyc out_inst", out_inst, exp_q[0][31:0]);
        check("cyc out_err", 32'(out_err), 32'(exp_q[0][32]));
      end
      check("cyc enc_cnt", 32'(enc_cnt), 32'(m_enc));
      check("cyc err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [11:0] c, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    in_code = c; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
  endtask

  // One word into an empty FIFO, checked against literals one cycle later, then drained.
  task automatic directed(input string nm, input logic [11:0] c, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                          input logic [31:0] x_inst, input logic x_err,
                          input logic [31:0] x_enc, input logic [31:0] x_errc);
    @(negedge clk);
    drive(c, d, s1, s2, im);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " out_valid"}, 32'(out_valid), 32'd1);
    check({nm, " out_inst"}, out_inst, x_inst);
    check({nm, " out_err"}, 32'(out_err), 32'(x_err));
    check({nm, " enc_cnt"}, 32'(enc_cnt), x_enc);
    check({nm, " err_cnt"}, 32'(err_cnt), x_errc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [11:0] rand_code();
    logic [6:0] ops [11];
    logic [6:0] op;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h73, 7'h13, 7'h23, 7'h63, 7'h33, 7'h18};
    if ($urandom_range(0, 19) == 0) return 12'hFFF;
    if ($urandom_range(0, 9) == 0) op = 7'($urandom());
    else op = ops[$urandom_range(0, 10)];
    return {2'($urandom()), 3'($urandom()), op};
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [32:0] pin;
  bit          last_acc;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_inst", out_inst, 32'h0);
    check("rst out_err", 32'(out_err), 32'd0);
    check("rst enc_cnt", 32'(enc_cnt), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    // Pin the model on literal encodings
    pin = model_enc(12'h013, 5'd1, 5'd2, 5'd0, 32'd5);
    check("model addi", pin[31:0], 32'h0051_0093);
    pin = model_enc(12'h833, 5'd3, 5'd1, 5'd2, 32'd0);
    check("model sub", pin[31:0], 32'h4020_81B3);
    pin = model_enc(12'h063, 5'd0, 5'd1, 5'd2, 32'd8);
    check("model beq", pin[31:0], 32'h0020_8463);
    pin = model_enc(12'hFFF, 5'd0, 5'd0, 5'd0, 32'd0);
    check("model illisn", 32'(pin[32]), 32'd1);

    // Directed literal cases
    directed("addi", 12'h013, 5'd1, 5'd2, 5'd0, 32'd5, 32'h0051_0093, 1'b0, 1, 0);
    directed("sub",  12'h833, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0, 2, 0);
    directed("beq",  12'h063, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0, 3, 0);
    directed("illisn", 12'hFFF, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 3, 1);
`ifdef ENC_IRQ_EN
    directed("irq", 12'h098, 5'd1, 5'd2, 5'd9, 32'd0, 32'h0001_1098, 1'b0, 4, 1);
`else
    directed("irq", 12'h098, 5'd1, 5'd2, 5'd9, 32'd0, 32'h0000_0013, 1'b1, 3, 2);
`endif
    // Store with imm: sw x5, -4(x6) -> imm=FFFFFFFC
    directed("sw", 12'h123, 5'd0, 5'd6, 5'd5, 32'hFFFF_FFFC, 32'hFE53_2E23, 1'b0,
`ifdef ENC_IRQ_EN
             5, 1);
`else
             4, 2);
`endif

    // Backpressure: three back-to-back words with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    drive(12'h013, 5'd1, 5'd0, 5'd0, 32'd1); in_valid = 1'b1;
    @(negedge clk);
    check("bp in_ready after 1", 32'(in_ready), 32'd1);
    drive(12'h013, 5'd2, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    check("bp in_ready after 2", 32'(in_ready), 32'd0);
    drive(12'h013, 5'd3, 5'd0, 5'd0, 32'd3);
    @(negedge clk);
    check("bp hold in_ready", 32'(in_ready), 32'd0);
    check("bp head w1", out_inst, 32'h0010_0093);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp in_ready after pop", 32'(in_ready), 32'd1);
    check("bp head w2", out_inst, 32'h0020_0113);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp head w3", out_inst, 32'h0030_0193);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp drained", 32'(out_valid), 32'd0);

    // Mid-operation reset with two entries buffered
    drive(12'h033, 5'd4, 5'd5, 5'd6, 32'd0); in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("mr buffered", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr out_valid", 32'(out_valid), 32'd0);
    check("mr enc_cnt", 32'(enc_cnt), 32'd0);
    check("mr err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mr no stale", 32'(out_valid), 32'd0);
    check("mr in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Randomized traffic; payload held until accepted
    last_acc = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        drive(rand_code(), 5'($urandom()), 5'($urandom()), 5'($urandom()), $urandom());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      last_acc  = in_valid && in_ready;
    end

    // Drain
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("final drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
